// File: rtl/imm_decode_stage.sv
// Immediate decode for RV32I/RV64I with operand-B select, held in a 2-entry valid/ready buffer.
// Latency 1 cycle (accept edge -> out_valid); in_ready is registered-only, so it drops while full even if out_ready is high.
module imm_decode_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_rs2,
    input  logic            in_alu_src,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output logic [XLEN-1:0] out_operand_b,
    output logic [2:0]      out_fmt,
    output logic            out_illegal
);
    localparam logic [2:0] FMT_R   = 3'd0;
    localparam logic [2:0] FMT_I   = 3'd1;
    localparam logic [2:0] FMT_S   = 3'd2;
    localparam logic [2:0] FMT_B   = 3'd3;
    localparam logic [2:0] FMT_U   = 3'd4;
    localparam logic [2:0] FMT_J   = 3'd5;
    localparam logic [2:0] FMT_ILL = 3'd7;

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [31:0]     imm32;
    logic [2:0]      dec_fmt;
    logic            dec_ill;
    logic [XLEN-1:0] dec_imm;
    logic [XLEN-1:0] dec_opb;

    assign opcode = in_instr[6:0];
    assign funct3 = in_instr[14:12];

    // Every format fits in 32 bits; widening to XLEN is a single sign extension below.
    always_comb begin
        imm32   = '0;
        dec_fmt = FMT_R;
        dec_ill = 1'b0;
        case (opcode)
            7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: begin
                dec_fmt = FMT_I;
                imm32   = {{20{in_instr[31]}}, in_instr[31:20]};
                if (opcode == 7'b0010011 && (funct3 == 3'b001 || funct3 == 3'b101)) begin
                    if (XLEN == 64) begin
                        imm32 = {26'd0, in_instr[25:20]};
                    end else if (in_instr[25]) begin
                        imm32   = '0;
                        dec_ill = 1'b1;
                    end else begin
                        imm32 = {27'd0, in_instr[24:20]};
                    end
                end
            end
            7'b0100011: begin
                dec_fmt = FMT_S;
                imm32   = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
            end
            7'b1100011: begin
                dec_fmt = FMT_B;
                imm32   = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                           in_instr[30:25], in_instr[11:8], 1'b0};
            end
            7'b0110111, 7'b0010111: begin
                dec_fmt = FMT_U;
                imm32   = {in_instr[31:12], 12'd0};
            end
            7'b1101111: begin
                dec_fmt = FMT_J;
                imm32   = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                           in_instr[20], in_instr[30:21], 1'b0};
            end
            7'b0110011: begin
                dec_fmt = FMT_R;
            end
            default: begin
                dec_fmt = FMT_ILL;
                dec_ill = 1'b1;
            end
        endcase
    end

    assign dec_imm = XLEN'($signed(imm32));
    assign dec_opb = in_alu_src ? dec_imm : in_rs2;

    logic [XLEN-1:0] imm_q [2];
    logic [XLEN-1:0] opb_q [2];
    logic [2:0]      fmt_q [2];
    logic            ill_q [2];
    logic [1:0]      count_q, count_d;
    logic            wr_ptr_q, wr_ptr_d;
    logic            rd_ptr_q, rd_ptr_d;
    logic            push, pop;

    assign in_ready  = (count_q != 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_comb begin
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            count_d  = 2'd0;
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
        end else begin
            if (push) wr_ptr_d = ~wr_ptr_q;
            if (pop)  rd_ptr_d = ~rd_ptr_q;
            case ({push, pop})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q  <= 2'd0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                imm_q[i] <= '0;
                opb_q[i] <= '0;
                fmt_q[i] <= FMT_R;
                ill_q[i] <= 1'b0;
            end
        end else begin
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            if (push && !flush) begin
                imm_q[wr_ptr_q] <= dec_imm;
                opb_q[wr_ptr_q] <= dec_opb;
                fmt_q[wr_ptr_q] <= dec_fmt;
                ill_q[wr_ptr_q] <= dec_ill;
            end
        end
    end

    assign out_imm       = imm_q[rd_ptr_q];
    assign out_operand_b = opb_q[rd_ptr_q];
    assign out_fmt       = fmt_q[rd_ptr_q];
    assign out_illegal   = ill_q[rd_ptr_q];
endmodule
